// File: rtl/ped_crossing_ctrl_if.sv
// Signal bundle between the traffic light controller side and the pedestrian stage.
// The remaining port exists only when PED_COUNTDOWN_EN is defined.
interface ped_crossing_ctrl_if #(
    parameter int CNT_W = 8
);
    logic [2:0]       light;
    logic             ped_req;
    logic             walk;
    logic             dont_walk;
    logic             req_pending;
    logic             fault;
`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] remaining;
`endif

    modport master (
        output light,
        output ped_req,
        input  walk,
        input  dont_walk,
        input  req_pending,
`ifdef PED_COUNTDOWN_EN
        input  remaining,
`endif
        input  fault
    );

    modport slave (
        input  light,
        input  ped_req,
        output walk,
        output dont_walk,
        output req_pending,
`ifdef PED_COUNTDOWN_EN
        output remaining,
`endif
        output fault
    );
endinterface

// File: rtl/ped_crossing_ctrl.sv
// Pedestrian WALK / flashing clearance sequencer keyed off the vehicle light's red entry.
// Optional countdown output is enabled with PED_COUNTDOWN_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | don't-walk steady, waiting for red entry with request
// S_WALK  | walk lamp on for WALK_CYCLES cycles
// S_CLEAR | walk off, don't-walk flashing for CLEAR_CYCLES cycles
module ped_crossing_ctrl #(
    parameter int WALK_CYCLES  = 16,
    parameter int CLEAR_CYCLES = 8,
    parameter int FLASH_HALF   = 2,
    parameter int CNT_W        = 8
) (
    input  logic                clk,
    input  logic                reset,
    ped_crossing_ctrl_if.slave  bus
);
    localparam logic [2:0] RED = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] flash_q, flash_d;
    logic [2:0]       light_q;
    logic             walk_q, walk_d;
    logic             dont_walk_q, dont_walk_d;
    logic             pend_q, pend_d;
    logic             fault_q, fault_d;
`ifdef PED_COUNTDOWN_EN
    logic [CNT_W-1:0] rem_q, rem_d;
`endif

    logic is_red, legal, red_entry, abort;

    assign is_red    = (bus.light == RED);
    assign legal     = $onehot(bus.light);
    assign red_entry = is_red && (light_q != RED);
    assign abort     = (state_q != S_IDLE) && !is_red;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            flash_q     <= '0;
            light_q     <= RED;
            walk_q      <= 1'b0;
            dont_walk_q <= 1'b1;
            pend_q      <= 1'b0;
            fault_q     <= 1'b0;
`ifdef PED_COUNTDOWN_EN
            rem_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flash_q     <= flash_d;
            light_q     <= bus.light;
            walk_q      <= walk_d;
            dont_walk_q <= dont_walk_d;
            pend_q      <= pend_d;
            fault_q     <= fault_d;
`ifdef PED_COUNTDOWN_EN
            rem_q       <= rem_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        flash_d     = flash_q;
        walk_d      = 1'b0;
        dont_walk_d = 1'b1;
        pend_d      = pend_q;
        fault_d     = !legal || abort;

        if ((state_q != S_WALK) && bus.ped_req)
            pend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (red_entry && (pend_q || bus.ped_req)) begin
                    state_d     = S_WALK;
                    cnt_d       = CNT_W'(WALK_CYCLES - 1);
                    walk_d      = 1'b1;
                    dont_walk_d = 1'b0;
                    pend_d      = 1'b0;
                end
            end
            S_WALK: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_CLEAR;
                    cnt_d   = CNT_W'(CLEAR_CYCLES - 1);
                    flash_d = CNT_W'(FLASH_HALF - 1);
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    walk_d      = 1'b1;
                    dont_walk_d = 1'b0;
                end
            end
            S_CLEAR: begin
                if (abort || (cnt_q == '0)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    flash_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // dont_walk_q is the flash phase itself; toggle at each half-period end
                    if (flash_q == '0) begin
                        dont_walk_d = !dont_walk_q;
                        flash_d     = CNT_W'(FLASH_HALF - 1);
                    end else begin
                        dont_walk_d = dont_walk_q;
                        flash_d     = flash_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                flash_d = '0;
            end
        endcase
    end

`ifdef PED_COUNTDOWN_EN
    always_comb begin
        rem_d = '0;
        if (state_d != S_IDLE)
            rem_d = cnt_d + CNT_W'(1);
    end
    assign bus.remaining = rem_q;
`endif

    assign bus.walk        = walk_q;
    assign bus.dont_walk   = dont_walk_q;
    assign bus.req_pending = pend_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl: directed scenarios then randomized light/request traffic
// compared each cycle against an elapsed-time reference model.
module tb_ped_crossing_ctrl;
    localparam int WALK_CYCLES  = 16;
    localparam int CLEAR_CYCLES = 8;
    localparam int FLASH_HALF   = 2;
    localparam int CNT_W        = 8;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ped_crossing_ctrl_if #(.CNT_W(CNT_W)) bus ();

    ped_crossing_ctrl #(
        .WALK_CYCLES (WALK_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES),
        .FLASH_HALF  (FLASH_HALF),
        .CNT_W       (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 walk, 2 clear; elapsed counts cycles spent in the interval
    int         m_mode;
    int         m_elapsed;
    logic [2:0] m_prev;
    logic       m_pend;
    logic       m_fault;

    task automatic model_reset();
        m_mode    = 0;
        m_elapsed = 0;
        m_prev    = L_RED;
        m_pend    = 1'b0;
        m_fault   = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] l, input logic r);
        bit red, legal, entry, go_walk;
        red     = (l == L_RED);
        legal   = ($countones(l) == 1);
        entry   = red && (m_prev != L_RED);
        m_fault = !legal || ((m_mode != 0) && !red);
        go_walk = (m_mode == 0) && entry && (m_pend || r);
        if (go_walk)
            m_pend = 1'b0;
        else if ((m_mode != 1) && r)
            m_pend = 1'b1;
        case (m_mode)
            0: if (go_walk) begin m_mode = 1; m_elapsed = 0; end
            1: begin
                if (!red) m_mode = 0;
                else if (m_elapsed == WALK_CYCLES - 1) begin m_mode = 2; m_elapsed = 0; end
                else m_elapsed++;
            end
            default: begin
                if (!red || (m_elapsed == CLEAR_CYCLES - 1)) m_mode = 0;
                else m_elapsed++;
            end
        endcase
        m_prev = l;
    endtask

    task automatic check_all(input string tag);
        bit e_walk, e_dw;
        e_walk = (m_mode == 1);
        e_dw   = (m_mode == 0) || ((m_mode == 2) && (((m_elapsed / FLASH_HALF) % 2) == 0));
        check_eq({tag, ".walk"},        32'(bus.walk),        32'(e_walk));
        check_eq({tag, ".dont_walk"},   32'(bus.dont_walk),   32'(e_dw));
        check_eq({tag, ".req_pending"}, 32'(bus.req_pending), 32'(m_pend));
        check_eq({tag, ".fault"},       32'(bus.fault),       32'(m_fault));
        check_eq({tag, ".exclusive"},   32'(bus.walk & bus.dont_walk), 32'd0);
`ifdef PED_COUNTDOWN_EN
        check_eq({tag, ".remaining"},   32'(bus.remaining),
                 (m_mode == 1) ? 32'(WALK_CYCLES - m_elapsed) :
                 (m_mode == 2) ? 32'(CLEAR_CYCLES - m_elapsed) : 32'd0);
`endif
    endtask

    // Called at a negedge: drive inputs, step model at posedge, check at next negedge
    task automatic cycle(input string tag, input logic [2:0] l, input logic r);
        bus.light   = l;
        bus.ped_req = r;
        @(posedge clk);
        model_step(l, r);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        check_all(tag);
        reset = 1'b0;
    endtask

    initial begin
        logic [2:0] l;
        int         dur;
        int         pick;

        reset       = 1'b1;
        bus.light   = L_RED;
        bus.ped_req = 1'b0;
        model_reset();
        #12;
        check_all("por");
        @(negedge clk);
        reset = 1'b0;

        repeat (3) cycle("post_rst_red", L_RED, 1'b0);

        // full service: request during green, red held 30 cycles
        cycle("t2_grn", L_GRN, 1'b1);
        cycle("t2_grn", L_GRN, 1'b0);
        repeat (30) cycle("t2_red", L_RED, 1'b0);

        // no request across green-yellow-red
        repeat (3) cycle("t3_grn", L_GRN, 1'b0);
        repeat (2) cycle("t3_yel", L_YEL, 1'b0);
        repeat (6) cycle("t3_red", L_RED, 1'b0);

        // request coincident with red entry
        repeat (2) cycle("t4_grn", L_GRN, 1'b0);
        cycle("t4_entry", L_RED, 1'b1);
        repeat (28) cycle("t4_red", L_RED, 1'b0);

        // abort in the 5th walk cycle, then a request in the fault cycle
        cycle("t5_grn", L_GRN, 1'b1);
        repeat (5) cycle("t5_red", L_RED, 1'b0);
        cycle("t5_abort", L_GRN, 1'b0);
        cycle("t5_req", L_GRN, 1'b1);
        repeat (2) cycle("t5_grn", L_GRN, 1'b0);

        // illegal code while idle
        repeat (2) cycle("t6_ill", 3'b110, 1'b0);
        repeat (2) cycle("t6_yel", L_YEL, 1'b0);

        // mid-walk asynchronous reset, red persists afterwards
        cycle("t1_grn", L_GRN, 1'b1);
        repeat (6) cycle("t1_red", L_RED, 1'b0);
        async_reset("t1_rst");
        repeat (5) cycle("t1_after", L_RED, 1'b0);

        // abort during clearance with request
        cycle("tc_grn", L_GRN, 1'b1);
        repeat (19) cycle("tc_red", L_RED, 1'b0);
        cycle("tc_abort", L_YEL, 1'b1);
        repeat (2) cycle("tc_yel", L_YEL, 1'b0);

        for (int seg = 0; seg < 150; seg++) begin
            pick = $urandom_range(0, 19);
            if (pick == 0) begin
                do l = 3'($urandom_range(0, 7)); while ($countones(l) == 1);
            end else if (pick < 7) l = L_GRN;
            else if (pick < 10)    l = L_YEL;
            else                   l = L_RED;
            dur = (l == L_RED) ? $urandom_range(1, 35) : $urandom_range(1, 6);
            for (int k = 0; k < dur; k++)
                cycle("rand", l, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 39) == 0)
                async_reset("rand_rst");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
